lcd_rx_capture: RTL and testbench

Receive-side counterpart of the RGB LCD timing driver. Samples a DE-mode RGB565 stream (lcd_hs/lcd_vs unused, tied high) on the pixel clock, recovers pixel coordinates and frame boundaries from lcd_de alone, and measures active resolution. Sits at the input of the capture path (FPGA-to-FPGA loopback or external DE-mode source) and feeds a frame-buffer writer.

---
 rtl/lcd_rx_capture.sv | 232 +++++++++++++++++++++++
 tb/tb_lcd_rx_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx_capture.sv
// lcd_rx_capture: receive side of a DE-mode RGB565 LCD link.
// Recovers pixel coordinates and frame boundaries from lcd_de alone and
// measures the active resolution of each completed frame.
//
// state   | meaning
// --------+------------------------------------------------------------
// WAIT_VB | after reset; input ignored until a full vertical gap is seen
// VBLANK  | in vertical blanking; next DE starts a new frame at (0,0)
// LINE    | inside an active line, one pixel per DE sample
// HBLANK  | between lines; DE starts the next row, long gap ends frame

module lcd_rx_capture #(
    parameter int VBLANK_MIN = 1500
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        lcd_de,
    input  logic [15:0] lcd_rgb,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] meas_h_disp,
    output logic [10:0] meas_v_disp,
    output logic        meas_valid,
    output logic        frame_err
);

    localparam logic [10:0] GAP_MAX   = 11'(VBLANK_MIN);
    localparam logic [10:0] COORD_MAX = 11'd2047;

    typedef enum logic [1:0] {
        WAIT_VB = 2'd0,
        VBLANK  = 2'd1,
        LINE    = 2'd2,
        HBLANK  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [10:0] gap_cnt;
    logic        gap_reached;

    // x_cnt is one bit wider so a line that runs past column 2047 is visible
    logic [11:0] x_cnt;
    logic [10:0] y_cnt;
    logic [11:0] ref_width;
    logic        ref_set;
    logic        mismatch;

    logic        emit_first;
    logic        emit_next_line;
    logic        emit_pixel;
    logic        line_end;
    logic        frame_end;
    logic        emit_any;
    logic        x_ovf;
    logic        y_ovf;
    logic [10:0] x_now;
    logic [10:0] y_now;
    logic        size_unreportable;

    // The sample that brings the gap counter to VBLANK_MIN
    assign gap_reached = !lcd_de && (gap_cnt == GAP_MAX - 11'd1);

    // Count consecutive DE-low samples, saturating at VBLANK_MIN
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (lcd_de) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + 11'd1;
        end
    end

    // FSM state register
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_VB;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-sample event strobes
    always_comb begin
        state_next     = state;
        emit_first     = 1'b0;
        emit_next_line = 1'b0;
        emit_pixel     = 1'b0;
        line_end       = 1'b0;
        frame_end      = 1'b0;
        case (state)
            WAIT_VB: begin
                if (gap_reached) begin
                    state_next = VBLANK;
                end
            end
            VBLANK: begin
                if (lcd_de) begin
                    state_next = LINE;
                    emit_first = 1'b1;
                end
            end
            LINE: begin
                if (lcd_de) begin
                    emit_pixel = 1'b1;
                end else begin
                    state_next = HBLANK;
                    line_end   = 1'b1;
                end
            end
            HBLANK: begin
                if (lcd_de) begin
                    state_next     = LINE;
                    emit_next_line = 1'b1;
                end else if (gap_reached) begin
                    state_next = VBLANK;
                    frame_end  = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_VB;
            end
        endcase
    end

    assign emit_any = emit_first | emit_next_line | emit_pixel;
    assign x_ovf    = emit_pixel && x_cnt[11];
    assign y_ovf    = emit_next_line && (y_cnt == COORD_MAX);

    // Coordinates of the pixel sampled this cycle (saturating at 2047)
    always_comb begin
        x_now = '0;
        y_now = y_cnt;
        if (emit_pixel) begin
            x_now = x_cnt[11] ? COORD_MAX : x_cnt[10:0];
        end
        if (emit_first) begin
            y_now = '0;
        end else if (emit_next_line) begin
            y_now = y_ovf ? COORD_MAX : (y_cnt + 11'd1);
        end
    end

    // Registered pixel output stage, one cycle after the sample
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= emit_any;
            frame_start <= emit_first;
            if (emit_any) begin
                pix_data <= lcd_rgb;
                pix_x    <= x_now;
                pix_y    <= y_now;
            end
        end
    end

    // Line/row counters, reference width and per-frame mismatch tracking
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            ref_width <= '0;
            ref_set   <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            if (emit_first || emit_next_line) begin
                x_cnt <= 12'd1;
                y_cnt <= y_now;
            end else if (emit_pixel && !x_cnt[11]) begin
                x_cnt <= x_cnt + 12'd1;
            end

            if (emit_first) begin
                ref_set  <= 1'b0;
                mismatch <= 1'b0;
            end else begin
                if (x_ovf || y_ovf) begin
                    mismatch <= 1'b1;
                end
                if (line_end) begin
                    if (!ref_set) begin
                        ref_width <= x_cnt;
                        ref_set   <= 1'b1;
                    end else if (x_cnt != ref_width) begin
                        mismatch <= 1'b1;
                    end
                end
            end
        end
    end

    // A 2048-wide or 2048-tall frame cannot be reported on 11 bits;
    // flag it as an error instead of letting the measurement wrap to 0.
    assign size_unreportable = ref_width[11] || (y_cnt == COORD_MAX);

    // Frame completion pulse and resolution measurement update
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            meas_h_disp <= '0;
            meas_v_disp <= '0;
            meas_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                if (mismatch || size_unreportable) begin
                    meas_valid <= 1'b0;
                    frame_err  <= 1'b1;
                end else begin
                    meas_h_disp <= ref_width[10:0];
                    meas_v_disp <= y_cnt + 11'd1;
                    meas_valid  <= 1'b1;
                    frame_err   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_rx_capture.sv
// Testbench for lcd_rx_capture: frame-level reference model driving
// table-driven and randomized DE-mode frames, plus reset corner cases.

module tb_lcd_rx_capture;

    localparam int VB = 1500;

    logic        lcd_pclk = 1'b0;
    logic        rst_n;
    logic        lcd_de;
    logic [15:0] lcd_rgb;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_start;
    logic        frame_done;
    logic [10:0] meas_h_disp;
    logic [10:0] meas_v_disp;
    logic        meas_valid;
    logic        frame_err;

    lcd_rx_capture #(.VBLANK_MIN(VB)) dut (
        .lcd_pclk    (lcd_pclk),
        .rst_n       (rst_n),
        .lcd_de      (lcd_de),
        .lcd_rgb     (lcd_rgb),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .meas_h_disp (meas_h_disp),
        .meas_v_disp (meas_v_disp),
        .meas_valid  (meas_valid),
        .frame_err   (frame_err)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int checks   = 0;
    int failures = 0;

    // Expected measurement outputs, held between frame completions
    int   m_h;
    int   m_v;
    logic m_valid;
    logic m_err;

    typedef struct {
        int   w;
        int   h;
        int   hgap;
        int   vgap;
        int   bad_line;
        int   bad_w;
        int   exp_h;
        int   exp_v;
        logic exp_valid;
        logic exp_err;
    } frame_vec_t;

    frame_vec_t tbl[9];

    // Drive one sample and compare the outputs that follow its edge
    task automatic step(input logic de, input logic [15:0] rgb, input logic ev,
                        input int ex, input int ey, input logic efs, input logic efd);
        lcd_de  = de;
        lcd_rgb = rgb;
        @(posedge lcd_pclk);
        #1;
        checks++;
        if (pix_valid !== ev || frame_start !== efs || frame_done !== efd ||
            meas_h_disp !== 11'(m_h) || meas_v_disp !== 11'(m_v) ||
            meas_valid !== m_valid || frame_err !== m_err ||
            (ev && (pix_x !== 11'(ex) || pix_y !== 11'(ey) || pix_data !== rgb))) begin
            failures++;
            $display("FAIL sample t=%0t got v=%0b x=%0d y=%0d d=%h fs=%0b fd=%0b mh=%0d mv=%0d mval=%0b err=%0b want v=%0b x=%0d y=%0d d=%h fs=%0b fd=%0b mh=%0d mv=%0d mval=%0b err=%0b",
                     $time, pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done,
                     meas_h_disp, meas_v_disp, meas_valid, frame_err,
                     ev, ex, ey, rgb, efs, efd, m_h, m_v, m_valid, m_err);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done,
             meas_h_disp, meas_v_disp, meas_valid, frame_err} !== 65'd0) begin
            failures++;
            $display("FAIL %s got outputs=%h want all zero", name,
                     {pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done,
                      meas_h_disp, meas_v_disp, meas_valid, frame_err});
        end
    endtask

    // Send one frame: h lines of w pixels (line bad_line has bad_w pixels),
    // hgap low samples between lines, vgap low samples after the last line.
    // capture says whether the receiver is locked and should report it.
    task automatic send_frame(input int w, input int h, input int hgap, input int vgap,
                              input int bad_line, input int bad_w, input logic capture);
        int  widths[$];
        int  wl;
        logic same;
        logic ovf;
        for (int l = 0; l < h; l++) begin
            wl = (l == bad_line) ? bad_w : w;
            widths.push_back(wl);
        end
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < widths[l]; p++) begin
                step(1'b1, 16'($urandom), capture, (p > 2047) ? 2047 : p,
                     (l > 2047) ? 2047 : l, capture && l == 0 && p == 0, 1'b0);
            end
            if (l < h - 1) begin
                for (int g = 0; g < hgap; g++) begin
                    step(1'b0, 16'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
                end
            end
        end
        for (int g = 1; g <= vgap; g++) begin
            if (capture && g == VB) begin
                same = 1'b1;
                ovf  = (h >= 2048);
                foreach (widths[k]) begin
                    if (widths[k] != widths[0]) same = 1'b0;
                    if (widths[k] >= 2048) ovf = 1'b1;
                end
                if (same && !ovf) begin
                    m_h     = widths[0];
                    m_v     = h;
                    m_valid = 1'b1;
                    m_err   = 1'b0;
                end else begin
                    m_valid = 1'b0;
                    m_err   = 1'b1;
                end
            end
            step(1'b0, 16'($urandom), 1'b0, 0, 0, 1'b0, capture && g == VB);
        end
    endtask

    initial begin
        int w;
        int h;
        int hg;
        int vg;
        int bl;
        int bw;

        //        w     h   hgap  vgap      bad  bad_w  meas_h meas_v valid err
        tbl[0] = '{32,   8,  10,   VB,       -1,  0,     32,    8,     1'b1, 1'b0};
        tbl[1] = '{32,   8,  1,    VB + 20,  -1,  0,     32,    8,     1'b1, 1'b0};
        tbl[2] = '{32,   8,  10,   VB,       3,   31,    32,    8,     1'b0, 1'b1};
        tbl[3] = '{32,   8,  10,   VB,       -1,  0,     32,    8,     1'b1, 1'b0};
        tbl[4] = '{48,   12, 20,   VB + 5,   -1,  0,     48,    12,    1'b1, 1'b0};
        tbl[5] = '{16,   3,  VB-1, VB,       -1,  0,     16,    3,     1'b1, 1'b0};
        tbl[6] = '{2050, 2,  5,    VB,       -1,  0,     16,    3,     1'b0, 1'b1};
        tbl[7] = '{20,   5,  7,    VB,       0,   25,    16,    3,     1'b0, 1'b1};
        tbl[8] = '{1,    1,  3,    VB,       -1,  0,     1,     1,     1'b1, 1'b0};

        m_h = 0; m_v = 0; m_valid = 1'b0; m_err = 1'b0;
        rst_n   = 1'b0;
        lcd_de  = 1'b0;
        lcd_rgb = '0;
        repeat (2) @(posedge lcd_pclk);
        #1;
        check_zero("reset_state");

        // Source already mid-frame while in reset, then reset released
        for (int p = 0; p < 5; p++) step(1'b1, 16'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        send_frame(32, 5, 10, VB, -1, 0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].w, tbl[i].h, tbl[i].hgap, tbl[i].vgap,
                       tbl[i].bad_line, tbl[i].bad_w, 1'b1);
            checks++;
            if (meas_h_disp !== 11'(tbl[i].exp_h) || meas_v_disp !== 11'(tbl[i].exp_v) ||
                meas_valid !== tbl[i].exp_valid || frame_err !== tbl[i].exp_err) begin
                failures++;
                $display("FAIL table[%0d] got mh=%0d mv=%0d mval=%0b err=%0b want mh=%0d mv=%0d mval=%0b err=%0b",
                         i, meas_h_disp, meas_v_disp, meas_valid, frame_err,
                         tbl[i].exp_h, tbl[i].exp_v, tbl[i].exp_valid, tbl[i].exp_err);
            end
        end

        // Reset pulse in the middle of a pixel burst
        for (int p = 0; p < 10; p++) step(1'b1, 16'($urandom), 1'b1, p, 0, p == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_h = 0; m_v = 0; m_valid = 1'b0; m_err = 1'b0;
        check_zero("async_reset");
        step(1'b1, 16'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        send_frame(16, 4, 8, VB, -1, 0, 1'b0);
        send_frame(24, 6, 4, VB, -1, 0, 1'b1);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 12; i++) begin
            w  = $urandom_range(1, 40);
            h  = $urandom_range(1, 10);
            hg = $urandom_range(1, 40);
            vg = $urandom_range(VB, VB + 100);
            bl = -1;
            bw = 0;
            if ($urandom_range(0, 3) == 0 && h > 1) begin
                bl = $urandom_range(0, h - 1);
                bw = (w > 1 && $urandom_range(0, 1) == 1) ? w - 1 : w + 1;
            end
            send_frame(w, h, hg, vg, bl, bw, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
